mealy_seq_scan_ctrl: RTL and testbench

- Sequencing controller for the serial overlapping-pattern detector datapath.
- Accepts a parallel data word and a programmable PLEN-bit pattern on a start handshake, then shifts the word out MSB-first, one bit per clock.
- Detects every overlapping occurrence of the pattern and reports match count, first-match position and a one-cycle done pulse.
- Sits between a host or register interface and the bit-serial detection logic; lets a parallel source use the detector without hand-driving x each cycle.

---
 rtl/mealy_seq_scan_ctrl_if.sv | 27 ++
 rtl/mealy_seq_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_mealy_seq_scan_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mealy_seq_scan_ctrl_if.sv
// rtl/mealy_seq_scan_ctrl_if.sv - host-side request/result bundle of the pattern scan controller
interface mealy_seq_scan_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int PLEN  = 4,
  parameter int CNT_W = 5,
  parameter int POS_W = 4
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] data_in;
  logic [PLEN-1:0]  pattern;
  logic             busy;
  logic             done;
  logic             found;
  logic [CNT_W-1:0] match_count;
  logic [POS_W-1:0] first_pos;

  modport master (
    output start, abort, data_in, pattern,
    input  busy, done, found, match_count, first_pos
  );

  modport slave (
    input  start, abort, data_in, pattern,
    output busy, done, found, match_count, first_pos
  );
endinterface

// File: rtl/mealy_seq_scan_ctrl.sv
// rtl/mealy_seq_scan_ctrl.sv - shifts a captured word MSB-first and counts overlapping pattern matches
module mealy_seq_scan_ctrl #(
  parameter int WIDTH = 16,
  parameter int PLEN  = 4,
  parameter int CNT_W = 5,
  parameter int POS_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  mealy_seq_scan_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [POS_W-1:0] LAST_IDX  = POS_W'(WIDTH - 1);
  localparam logic [POS_W-1:0] FIRST_HIT = POS_W'(PLEN - 1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [PLEN-1:0]   pat_q, pat_d;
  logic [PLEN-2:0]   win_q, win_d;
  logic [POS_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              found_q, found_d;
  logic [POS_W-1:0]  fpos_q, fpos_d;

  logic [PLEN-1:0]   win_next;
  logic              hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      pat_q   <= '0;
      win_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      found_q <= 1'b0;
      fpos_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      pat_q   <= pat_d;
      win_q   <= win_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      found_q <= found_d;
      fpos_q  <= fpos_d;
    end
  end

  // The word register shifts left each SCAN cycle, so its MSB is always the current bit.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    pat_d    = pat_q;
    win_d    = win_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    found_d  = found_q;
    fpos_d   = fpos_q;
    win_next = {win_q, data_q[WIDTH-1]};
    hit      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SCAN;
          data_d  = bus.data_in;
          pat_d   = bus.pattern;
          win_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
          found_d = 1'b0;
          fpos_d  = '0;
        end
      end

      ST_SCAN: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          hit    = (idx_q >= FIRST_HIT) && (win_next == pat_q);
          win_d  = win_next[PLEN-2:0];
          data_d = {data_q[WIDTH-2:0], 1'b0};
          idx_d  = idx_q + POS_W'(1);
          if (hit) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!found_q) begin
              found_d = 1'b1;
              fpos_d  = idx_q;
            end
          end
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.busy        = (state_q == ST_SCAN);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.found       = found_q;
  assign bus.match_count = cnt_q;
  assign bus.first_pos   = fpos_q;

endmodule

// File: tb/tb_mealy_seq_scan_ctrl.sv
// tb/tb_mealy_seq_scan_ctrl.sv - directed bench with a per-cycle reference model of the scan controller
module tb_mealy_seq_scan_ctrl;

  localparam int WIDTH = 16;
  localparam int PLEN  = 4;
  localparam int CNT_W = 5;
  localparam int POS_W = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mealy_seq_scan_ctrl_if #(.WIDTH(WIDTH), .PLEN(PLEN), .CNT_W(CNT_W), .POS_W(POS_W)) bus ();

  mealy_seq_scan_ctrl #(.WIDTH(WIDTH), .PLEN(PLEN), .CNT_W(CNT_W), .POS_W(POS_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: results depend only on the captured word, the pattern and how many bits were consumed.
  function automatic int ref_count(input logic [WIDTH-1:0] w, input logic [PLEN-1:0] p, input int consumed);
    int n;
    logic [WIDTH-1:0] seg;
    n = 0;
    for (int e = PLEN - 1; e < consumed; e++) begin
      seg = (w >> (WIDTH - 1 - e)) & WIDTH'((1 << PLEN) - 1);
      if (seg[PLEN-1:0] == p) n++;
    end
    return n;
  endfunction

  function automatic int ref_first(input logic [WIDTH-1:0] w, input logic [PLEN-1:0] p, input int consumed);
    logic [WIDTH-1:0] seg;
    for (int e = PLEN - 1; e < consumed; e++) begin
      seg = (w >> (WIDTH - 1 - e)) & WIDTH'((1 << PLEN) - 1);
      if (seg[PLEN-1:0] == p) return e;
    end
    return 0;
  endfunction

  logic             m_active;
  logic             m_done;
  int               m_consumed;
  logic [WIDTH-1:0] m_word;
  logic [PLEN-1:0]  m_pat;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active   = 1'b0;
      m_done     = 1'b0;
      m_consumed = 0;
      m_word     = '0;
      m_pat      = '0;
    end else if (m_active) begin
      if (bus.abort) begin
        m_active = 1'b0;
      end else begin
        m_consumed++;
        if (m_consumed == WIDTH) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (bus.start) begin
      m_active   = 1'b1;
      m_word     = bus.data_in;
      m_pat      = bus.pattern;
      m_consumed = 0;
    end
  end

  initial begin
    int c;
    forever begin
      @(posedge clk);
      #2;
      c = ref_count(m_word, m_pat, m_consumed);
      chk("busy", int'(bus.busy), int'(m_active));
      chk("done", int'(bus.done), int'(m_done));
      chk("found", int'(bus.found), int'(c > 0));
      chk("match_count", int'(bus.match_count), c);
      chk("first_pos", int'(bus.first_pos), ref_first(m_word, m_pat, m_consumed));
    end
  end

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(posedge clk);
      #2;
      lat++;
    end
    if (!bus.done) begin
      errors++;
      $display("FAIL wait_done: done not seen within %0d cycles", lat);
    end
  endtask

  // Accept a start on the next edge; leaves the caller just after that edge's negedge.
  task automatic launch(input logic [WIDTH-1:0] d, input logic [PLEN-1:0] p, input bit hold);
    @(negedge clk);
    bus.data_in = d;
    bus.pattern = p;
    bus.start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (hold) bus.data_in = ~d;
    else      bus.start   = 1'b0;
  endtask

  task automatic scan_and_check(input string tag, input logic [WIDTH-1:0] d, input logic [PLEN-1:0] p,
                                input int exp_cnt, input int exp_found, input int exp_pos);
    int lat;
    launch(d, p, 1'b0);
    wait_done(lat);
    chk({tag, "_latency"}, lat, 16);
    chk({tag, "_count"}, int'(bus.match_count), exp_cnt);
    chk({tag, "_found"}, int'(bus.found), exp_found);
    chk({tag, "_pos"}, int'(bus.first_pos), exp_pos);
    @(posedge clk);
    #2;
    chk({tag, "_done_pulse_one_cycle"}, int'(bus.done), 0);
  endtask

  initial begin
    int lat;
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.data_in = '0;
    bus.pattern = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_count", int'(bus.match_count), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    scan_and_check("b6d6", 16'hB6D6, 4'b1011, 4, 1, 3);
    scan_and_check("ffff", 16'hFFFF, 4'b1111, 13, 1, 3);
    scan_and_check("zero", 16'h0000, 4'b1011, 0, 0, 0);

    // Start held through the whole scan while data_in changes; re-accept two edges after done.
    launch(16'hB6D6, 4'b1011, 1'b1);
    wait_done(lat);
    chk("hold_count", int'(bus.match_count), 4);
    chk("hold_pos", int'(bus.first_pos), 3);
    @(posedge clk);
    #2;
    chk("hold_idle_gap", int'(bus.busy), 0);
    @(posedge clk);
    #2;
    chk("hold_restart", int'(bus.busy), 1);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat);
    chk("hold_second_count", int'(bus.match_count), ref_count(16'h4929, 4'b1011, WIDTH));

    // Abort while idx=8 is the current bit.
    repeat (2) @(posedge clk);
    launch(16'hB6D6, 4'b1011, 1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #2;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_count", int'(bus.match_count), 2);
    chk("abort_pos", int'(bus.first_pos), 3);
    @(negedge clk);
    bus.abort = 1'b0;
    repeat (20) @(posedge clk);

    // Start and abort together in IDLE: start is taken.
    @(negedge clk);
    bus.data_in = 16'hFFFF;
    bus.pattern = 4'b1111;
    bus.start   = 1'b1;
    bus.abort   = 1'b1;
    @(posedge clk);
    #2;
    chk("start_beats_abort", int'(bus.busy), 1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    wait_done(lat);
    chk("sa_count", int'(bus.match_count), 13);

    // Asynchronous reset between clock edges mid-scan.
    repeat (2) @(posedge clk);
    launch(16'hB6D6, 4'b1011, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("areset_busy", int'(bus.busy), 0);
    chk("areset_count", int'(bus.match_count), 0);
    chk("areset_found", int'(bus.found), 0);
    chk("areset_pos", int'(bus.first_pos), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    scan_and_check("post_reset", 16'hB6D6, 4'b1011, 4, 1, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
